// File: rtl/score_bcd_accum_if.sv
// Handshake and display bus between the jump logic / HEX path and score_bcd_accum.
// master = producer of increments and game-over, slave = the score accumulator.
interface score_bcd_accum_if #(
  parameter int DIGITS = 5,
  parameter int INC_W  = 8
);
  logic                  inc_valid;
  logic [INC_W-1:0]      inc_amount;
  logic                  inc_ready;
  logic                  game_over;
  logic [4*DIGITS-1:0]   Score;
  logic [4*DIGITS-1:0]   HiScore;
  logic                  busy;
  logic                  sat;

  modport master (
    output inc_valid, inc_amount, game_over,
    input  inc_ready, Score, HiScore, busy, sat
  );

  modport slave (
    input  inc_valid, inc_amount, game_over,
    output inc_ready, Score, HiScore, busy, sat
  );
endinterface

// File: rtl/score_bcd_accum.sv
// Saturating packed-BCD score accumulator: double-dabble each binary increment, then a
// digit-serial BCD add. Define SCORE_HISCORE_EN to build the high-score register.
module score_bcd_accum #(
  parameter int DIGITS = 5,
  parameter int INC_W  = 8
) (
  input logic               Clk,
  input logic               Reset,
  score_bcd_accum_if.slave  bus
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = (INC_W  > 1) ? $clog2(INC_W)  : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, CONV, ADD, CLEAR} state_e;

  state_e            state_q,   state_d;
  logic [INC_W-1:0]  amt_q,     amt_d;
  logic [SW-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              carry_q,   carry_d;
  logic [SW-1:0]     work_q,    work_d;
  logic [SW-1:0]     score_q,   score_d;
  logic              sat_q,     sat_d;
  logic              pending_q, pending_d;
`ifdef SCORE_HISCORE_EN
  logic [SW-1:0]     hi_q,      hi_d;
`endif

  logic [SW-1:0]     adj;
  logic [4:0]        sum;
  logic              carry_nx;

  assign bus.inc_ready = (state_q == IDLE) & ~bus.game_over & ~pending_q;
  assign bus.busy      = (state_q != IDLE) | pending_q;
  assign bus.Score     = score_q;
  assign bus.sat       = sat_q;
`ifdef SCORE_HISCORE_EN
  assign bus.HiScore   = hi_q;
`else
  assign bus.HiScore   = '0;
`endif

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a variable
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d   = state_q;
    amt_d     = amt_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    work_d    = work_q;
    score_d   = score_q;
    sat_d     = sat_q;
    pending_d = pending_q;
`ifdef SCORE_HISCORE_EN
    hi_d      = hi_q;
`endif
    adj       = scratch_q;
    sum       = '0;
    carry_nx  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.game_over || pending_q) begin
          state_d = CLEAR;
        end else if (bus.inc_valid) begin
          amt_d     = bus.inc_amount;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end

      CONV: begin
        pending_d = pending_q | bus.game_over;
        for (int i = 0; i < DIGITS; i++) begin
          if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        scratch_d = {adj[SW-2:0], amt_q[INC_W-1]};
        amt_d     = amt_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INC_W - 1)) begin
          state_d = ADD;
          idx_d   = '0;
          carry_d = 1'b0;
          work_d  = score_q;
        end
      end

      ADD: begin
        pending_d = pending_q | bus.game_over;
        // Constant-index mux over digits keeps the datapath a plain 4-bit adder.
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum = {1'b0, score_q[4*i +: 4]} + {1'b0, scratch_q[4*i +: 4]} + {4'b0, carry_q};
            if (sum > 5'd9) begin
              work_d[4*i +: 4] = 4'(sum - 5'd10);
              carry_nx         = 1'b1;
            end else begin
              work_d[4*i +: 4] = sum[3:0];
              carry_nx         = 1'b0;
            end
          end
        end
        carry_d = carry_nx;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          // Score is committed in one step here; a carry out of the top digit saturates.
          if (carry_nx) begin
            score_d = NINES;
            sat_d   = 1'b1;
          end else begin
            score_d = work_d;
          end
          state_d = (pending_q || bus.game_over) ? CLEAR : IDLE;
        end
      end

      CLEAR: begin
`ifdef SCORE_HISCORE_EN
        // Packed BCD orders the same as unsigned binary, so a plain compare suffices.
        if (score_q > hi_q) hi_d = score_q;
`endif
        score_d   = '0;
        sat_d     = 1'b0;
        pending_d = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      amt_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      work_q    <= '0;
      score_q   <= '0;
      sat_q     <= 1'b0;
      pending_q <= 1'b0;
`ifdef SCORE_HISCORE_EN
      hi_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      amt_q     <= amt_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      work_q    <= work_d;
      score_q   <= score_d;
      sat_q     <= sat_d;
      pending_q <= pending_d;
`ifdef SCORE_HISCORE_EN
      hi_q      <= hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Directed bench for score_bcd_accum with a decimal scoreboard model; honours SCORE_HISCORE_EN.
module tb_score_bcd_accum;

  localparam int DIGITS = 5;
  localparam int INC_W  = 8;
  localparam int MAX_SCORE = 99999;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  score_bcd_accum_if #(.DIGITS(DIGITS), .INC_W(INC_W)) bus ();

  score_bcd_accum #(.DIGITS(DIGITS), .INC_W(INC_W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4*DIGITS-1:0] score;
    logic                sat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   model_score = 0;
  int   model_hi    = 0;
  logic model_sat   = 1'b0;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inc(input int amt);
    model_score += amt;
    if (model_score > MAX_SCORE) begin
      model_score = MAX_SCORE;
      model_sat   = 1'b1;
    end
    sb.push_back('{to_bcd(model_score), model_sat});
  endtask

  task automatic apply_clear();
`ifdef SCORE_HISCORE_EN
    if (model_score > model_hi) model_hi = model_score;
`else
    model_hi = 0;
`endif
    model_score = 0;
    model_sat   = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_score"}, bus.Score, e.score);
      check({tag, "_sat"},   bus.sat,   e.sat);
    end
  endtask

  // Accept one increment, wait (bounded) for completion, then score it.
  task automatic send_inc(input logic [INC_W-1:0] amt, input string tag);
    int                  lat;
    logic                early;
    logic [4*DIGITS-1:0] old;
    bus.inc_valid  = 1'b1;
    bus.inc_amount = amt;
    check({tag, "_ready_before"}, bus.inc_ready, 1'b1);
    step();
    bus.inc_valid = 1'b0;
    push_inc(int'(amt));
    old   = bus.Score;
    early = 1'b0;
    lat   = 0;
    while (!bus.inc_ready && lat < 40) begin
      step();
      lat++;
      if (!bus.inc_ready && bus.Score !== old) early = 1'b1;
    end
    check({tag, "_latency"}, lat, INC_W + DIGITS);
    check({tag, "_no_early_update"}, early, 1'b0);
    pop_check(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4*DIGITS-1:0] old;

    rst            = 1'b1;
    bus.inc_valid  = 1'b0;
    bus.inc_amount = '0;
    bus.game_over  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    check("rst_score",   bus.Score,     '0);
    check("rst_hiscore", bus.HiScore,   '0);
    check("rst_sat",     bus.sat,       1'b0);
    check("rst_busy",    bus.busy,      1'b0);
    check("rst_ready",   bus.inc_ready, 1'b1);

    // Basic conversion and digit carries
    send_inc(8'h2A, "inc_42");
    check("score_42", bus.Score, 20'h00042);
    send_inc(8'h39, "inc_to_99");
    send_inc(8'h01, "ripple_100");
    check("score_100", bus.Score, 20'h00100);

    // Game-over in IDLE beats a simultaneous increment
    bus.game_over  = 1'b1;
    bus.inc_valid  = 1'b1;
    bus.inc_amount = 8'h05;
    #1;
    check("ready_gated_by_go", bus.inc_ready, 1'b0);
    step();
    bus.game_over = 1'b0;
    bus.inc_valid = 1'b0;
    check("clear_busy", bus.busy, 1'b1);
    step();
    apply_clear();
    check("go_score",   bus.Score,   '0);
    check("go_sat",     bus.sat,     1'b0);
    check("go_hiscore", bus.HiScore, to_bcd(model_hi));
    check("go_inc_dropped_busy", bus.busy, 1'b0);
    repeat (3) step();
    check("go_inc_dropped_score", bus.Score, '0);

    // Saturation: 393 x 255 overflows five digits
    for (int i = 0; i < 393; i++) send_inc(8'hFF, "sat_run");
    check("sat_score", bus.Score, 20'h99999);
    check("sat_flag",  bus.sat,   1'b1);
    send_inc(8'h01, "after_sat");
    check("after_sat_score", bus.Score, 20'h99999);

    // Reset from idle clears everything including HiScore
    rst = 1'b1;
    #1;
    check("rst2_score",   bus.Score,   '0);
    check("rst2_sat",     bus.sat,     1'b0);
    check("rst2_hiscore", bus.HiScore, '0);
    step();
    rst = 1'b0;
    model_score = 0;
    model_sat   = 1'b0;
    model_hi    = 0;

    // Deferred game-over during CONV
    send_inc(8'h32, "inc_50");
    bus.inc_valid  = 1'b1;
    bus.inc_amount = 8'h10;
    step();
    bus.inc_valid = 1'b0;
    push_inc(16);
    step();
    step();
    bus.game_over = 1'b1;
    step();
    bus.game_over = 1'b0;
    n   = 3;
    old = bus.Score;
    while (bus.Score === old && n < 40) begin
      step();
      n++;
    end
    check("defer_latency", n, INC_W + DIGITS);
    pop_check("defer");
    check("defer_score_66", bus.Score, 20'h00066);
    check("defer_busy_clear", bus.busy, 1'b1);
    step();
    apply_clear();
    check("defer_hiscore", bus.HiScore, to_bcd(model_hi));
    check("defer_score_0", bus.Score, '0);
    check("defer_sat",     bus.sat,   1'b0);
    check("defer_busy_0",  bus.busy,  1'b0);

    // Reset during ADD discards the in-flight increment
    send_inc(8'h05, "inc_5");
    bus.inc_valid  = 1'b1;
    bus.inc_amount = 8'h2A;
    step();
    bus.inc_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("midrst_score", bus.Score, '0);
    check("midrst_busy",  bus.busy,  1'b0);
    step();
    rst = 1'b0;
    model_score = 0;
    model_sat   = 1'b0;
    model_hi    = 0;
    repeat (20) step();
    check("midrst_no_late_score", bus.Score,     '0);
    check("midrst_ready",         bus.inc_ready, 1'b1);

    // Zero increment runs the full pipeline and leaves Score alone
    send_inc(8'h07, "inc_7");
    send_inc(8'h00, "inc_zero");
    check("zero_score", bus.Score, 20'h00007);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_accum.md
# score_bcd_accum

Converts per-event binary height increments from the jump logic into a saturating 5-digit packed-BCD score and a high-score register. The packed-BCD output drives the six-digit HEX display path and the score overlay in the colour mapper directly. Each increment is converted by double-dabble, then added one BCD digit per clock. Game-over clears the score and, when compiled in, updates the high score.

## Interface
Parameters:
- DIGITS, 5, number of BCD digits in Score/HiScore (score width = 4*DIGITS)
- INC_W, 8, width of binary increment input (double-dabble runs INC_W shift cycles)

Ports:
- Clk, in, 1, system clock (50 MHz)
- Reset, in, 1, reset, asynchronous, active-high
- inc_valid, in, 1, increment request
- inc_amount, in, INC_W, binary increment (pixels climbed)
- inc_ready, out, 1, increment accepted when inc_valid & inc_ready at rising Clk
- game_over, in, 1, single-cycle pulse: end of game
- Score, out, 4*DIGITS, current packed-BCD score, digit 0 in [3:0]
- HiScore, out, 4*DIGITS, packed-BCD high score
- busy, out, 1, high whenever state != IDLE or a game-over is pending
- sat, out, 1, sticky: score has saturated at all-nines

## Operation
- FSM states: IDLE, CONV, ADD, CLEAR.
- IDLE:
  - game_over or pending → CLEAR.
  - Otherwise an accepted increment latches inc_amount, clears the BCD scratch register and enters CONV with shift count 0.
- CONV:
  - Double-dabble, one bit per cycle, MSB first.
  - Any scratch digit ≥5 gets +3 before the shift.
  - After INC_W cycles → ADD with digit index 0 and carry 0.
- ADD:
  - One digit per cycle: sum = Score_work[i] + scratch[i] + carry.
  - If sum > 9: digit = sum − 10, carry = 1.
  - After digit DIGITS−1, go to IDLE.
  - If the final carry = 1, write all nines to Score and set sat; otherwise write the working copy to Score.
  - Score changes only at this single edge, never partially.
- CLEAR (one cycle):
  - Score ← 0, sat ← 0, pending ← 0.
  - HiScore ← Score if Score > HiScore (BCD compared as unsigned binary, valid for packed BCD).
  - Then → IDLE.
- pending:
  - Set when game_over arrives in CONV or ADD.
  - The in-flight increment completes first, and is included in HiScore.
- inc_ready = (state == IDLE) & ~game_over & ~pending. This is combinational from game_over.
- Simultaneous game_over and inc_valid in IDLE: game_over wins and the increment is not accepted.
- inc_amount = 0: full pipeline still runs (INC_W + DIGITS cycles) and Score is unchanged.
- Once sat is set, further increments leave Score at all-nines.

## Timing
- Reset values: Score = 0, HiScore = 0, sat = 0, busy = 0, inc_ready = 1 (absent game_over), state IDLE, pending = 0.
- Reset asserted mid-operation: immediate return to these values. The in-flight increment is discarded.
- Accept edge E0 → CONV at edges E1..E8 → ADD at edges E9..E13.
- Score updated at E13. Latency is INC_W + DIGITS = 13 cycles. inc_ready is high in the cycle after E13.
- Throughput: one increment per 14 cycles max. Game-over costs 1 extra cycle (CLEAR).
- Deferred game-over: CLEAR occupies the cycle after the E13 edge. HiScore and cleared Score are visible after the following edge.

## Configuration
- SCORE_HISCORE_EN
  - Defined: HiScore register and comparator are implemented as above.
  - Undefined: HiScore is tied to 0, no comparator. game_over still clears Score and sat via CLEAR.

## Test plan
- Reset, then idle 20 cycles → Score = 0x00000, HiScore = 0x00000, sat = 0, busy = 0, inc_ready = 1.
- From 0, inc_amount = 0x2A → Score = 0x00042 exactly 13 cycles after acceptance. inc_ready low for those 13 cycles.
- From 0x00099, inc_amount = 0x01 → Score = 0x00100 (carry ripples through two digits). sat = 0.
- 393 back-to-back increments of 0xFF from 0 → Score = 0x99999, sat = 1. A further 0x01 leaves Score = 0x99999.
- Score = 0x00050; inc 0x10 accepted; game_over pulsed 3 cycles later:
  - Score = 0x00066 after the E13 edge.
  - After the next edge: HiScore = 0x00066, Score = 0, sat = 0.
  - With SCORE_HISCORE_EN undefined: HiScore stays 0.
- Reset asserted during ADD of 0x2A → Score = 0x00000 immediately, busy = 0. No late update after deassertion.
